color_wheel_monitor: RTL
========================

// Module: color_wheel_monitor
// PURPOSE
//  Receive-side checker for the RGB colour-wheel LED drive. Samples red/green/blue pins,
//  filters glitches, decodes them to the wheel's 3-bit colour code and tracks the
//  RED>YELLOW>GREEN>CYAN>BLUE>MAGENTA>RED sequence and per-colour dwell time.
//  Sits on the board-test path beside the wheel generator; flags feed LEDs/UART status.
// PARAMETERS
//  BLINK_INTERVAL  2000000  nominal dwell per colour, clk cycles (12 MHz clk)
//  TOLERANCE       1024     allowed +/- dwell deviation, cycles
//  STABLE_CYCLES   4        consecutive identical samples needed to accept an RGB value (>=1)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous reset, active-high
//  red          in   1   red LED line (asynchronous to clk)
//  green        in   1   green LED line (asynchronous to clk)
//  blue         in   1   blue LED line (asynchronous to clk)
//  color        out  3   last accepted colour code
//  color_valid  out  1   color holds a legal wheel colour
//  locked       out  1   sequence and timing lock established
//  step         out  1   1-cycle pulse: legal in-time transition while locked
//  seq_error    out  1   1-cycle pulse: illegal colour or out-of-order transition
//  timing_error out  1   1-cycle pulse: dwell outside BLINK_INTERVAL+/-TOLERANCE
//  reverse      out  1   locked direction is reverse (0 when macro absent)
//  step_count   out  16  number of step pulses, wraps 0xFFFF->0x0000
// BEHAVIOUR
//  - Reset: state UNLOCKED, all outputs 0, counters 0, filter cleared.
//  - Input path: 2-flop synchroniser, then filter: new {r,g,b} accepted after STABLE_CYCLES
//    identical samples; shorter pulses ignored. Latency pin->color = STABLE_CYCLES+3 cycles.
//  - Decode {r,g,b}: 100 RED=000, 110 YELLOW=001, 010 GREEN=011, 011 CYAN=111,
//    001 BLUE=110, 101 MAGENTA=100. 000/111 illegal: color_valid=0, color holds last value.
//  - Dwell counter: cleared on each accepted change, saturating, width
//    $clog2(BLINK_INTERVAL+TOLERANCE+1)+1. Filter delay equal on both edges, cancels.
//  - Accepted-change events only (accepted value differing from previous accepted value):
//    UNLOCKED: legal colour -> ACQUIRE. Illegal -> seq_error, stay.
//    ACQUIRE: successor -> LOCKED, locked=1, no step, dwell not checked (partial interval).
//      Non-successor legal -> seq_error, stay ACQUIRE. Illegal -> seq_error, UNLOCKED.
//    LOCKED: successor, dwell in [BI-TOL, BI+TOL] -> step, step_count+1.
//      Successor, dwell < BI-TOL -> timing_error, stay LOCKED, no step.
//      Non-successor legal -> seq_error, locked=0, ACQUIRE. Illegal -> seq_error, UNLOCKED.
//  - Stall: in LOCKED, dwell reaching BI+TOL+1 with no change -> timing_error once,
//    locked=0, ACQUIRE; counter saturates, no further pulses.
//  - Pulses are registered, asserted the cycle after the event; step/errors mutually exclusive.
//  - Reset mid-operation wins over any event in the same cycle.
// CONFIGURATION
//  COLOR_WHEEL_MONITOR_REVERSE_EN defined: in ACQUIRE, predecessor also locks, sets
//   reverse=1; in LOCKED only the locked direction is legal; leaving LOCKED clears reverse.
//  Undefined: forward sequence only, predecessor is a sequence error, reverse tied 0.
// TESTING  (BLINK_INTERVAL=100, TOLERANCE=4, STABLE_CYCLES=4)
//  1 Clean wheel from RED, 100-cycle dwell, 18 changes -> locked after change 1,
//    17 step pulses, step_count=17, no error pulses.
//  2 While RED, 2-cycle glitch on green -> color stays 000, no pulses, step_count unchanged.
//  3 Locked, YELLOW->CYAN skipping GREEN -> seq_error 1 cycle, locked=0; next legal change
//    relocks without step, following change steps.
//  4 Dwells 97 -> step; 90 -> timing_error, still locked; hold 110 -> timing_error at
//    dwell 105, locked=0.
//  5 Drive 000 while locked -> seq_error, color_valid=0, UNLOCKED; reset mid-LOCKED -> all
//    outputs 0 next cycle.
//  6 Macro defined, MAGENTA>BLUE>CYAN -> locked, reverse=1, steps; macro undefined -> seq_error.

Source files
------------

// File: rtl/color_wheel_monitor.sv
// Receive-side checker for the RGB colour wheel: synchronise, glitch-filter, decode, track sequence and dwell.
// Optional reverse-direction locking is enabled by defining COLOR_WHEEL_MONITOR_REVERSE_EN.
module color_wheel_monitor #(
    parameter int unsigned BLINK_INTERVAL = 2000000,
    parameter int unsigned TOLERANCE      = 1024,
    parameter int unsigned STABLE_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        red,
    input  logic        green,
    input  logic        blue,
    output logic [2:0]  color,
    output logic        color_valid,
    output logic        locked,
    output logic        step,
    output logic        seq_error,
    output logic        timing_error,
    output logic        reverse,
    output logic [15:0] step_count
);

    localparam int unsigned DW = $clog2(BLINK_INTERVAL + TOLERANCE + 1) + 1;
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LO    = DW'((BLINK_INTERVAL > TOLERANCE) ? (BLINK_INTERVAL - TOLERANCE) : 0);
    localparam logic [DW-1:0] DWELL_HI    = DW'(BLINK_INTERVAL + TOLERANCE);
    localparam logic [DW-1:0] DWELL_STALL = DW'(BLINK_INTERVAL + TOLERANCE + 1);
    localparam logic [CW-1:0] RUN_FULL    = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    // Wheel position index 0..5 (RED..MAGENTA); 7 marks an illegal RGB pattern.
    function automatic logic [2:0] rgb_to_idx(input logic [2:0] v);
        case (v)
            3'b100:  return 3'd0;
            3'b110:  return 3'd1;
            3'b010:  return 3'd2;
            3'b011:  return 3'd3;
            3'b001:  return 3'd4;
            3'b101:  return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [2:0] idx_to_code(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b000;
            3'd1:    return 3'b001;
            3'd2:    return 3'b011;
            3'd3:    return 3'b111;
            3'd4:    return 3'b110;
            default: return 3'b100;
        endcase
    endfunction

    logic [2:0]    r_sync1, r_sync2, r_cand, r_acc;
    logic [CW-1:0] r_run, w_run;
    logic          r_chg;

    always_comb begin
        if (r_sync2 != r_cand)
            w_run = CW'(1);
        else if (r_run == RUN_FULL)
            w_run = RUN_FULL;
        else
            w_run = r_run + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cand  <= '0;
            r_run   <= '0;
            r_acc   <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_sync1 <= {red, green, blue};
            r_sync2 <= r_sync1;
            r_cand  <= r_sync2;
            r_run   <= w_run;
            r_chg   <= 1'b0;
            if (w_run == RUN_FULL && r_sync2 != r_acc) begin
                r_acc <= r_sync2;
                r_chg <= 1'b1;
            end
        end
    end

    state_t        r_state, w_state;
    logic [2:0]    r_idx, w_idx, r_color, w_color;
    logic          r_valid, w_valid, r_locked, w_locked, r_reverse, w_reverse;
    logic          r_step, w_step, r_seq_err, w_seq_err, r_tim_err, w_tim_err;
    logic [15:0]   r_step_count, w_step_count;
    logic [DW-1:0] r_dwell, w_dwell;
    logic [2:0]    w_new_idx, w_succ, w_pred;
    logic          w_legal, w_is_succ, w_is_pred, w_dir_ok;

    assign w_new_idx = rgb_to_idx(r_acc);
    assign w_legal   = (w_new_idx != 3'd7);
    assign w_succ    = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    assign w_pred    = (r_idx == 3'd0) ? 3'd5 : r_idx - 3'd1;
    assign w_is_succ = w_legal && (w_new_idx == w_succ);
    assign w_is_pred = w_legal && (w_new_idx == w_pred);
    assign w_dir_ok  = r_reverse ? w_is_pred : w_is_succ;
    assign w_dwell   = r_chg ? DW'(1) : ((r_dwell == '1) ? r_dwell : r_dwell + DW'(1));

    always_comb begin
        w_state      = r_state;
        w_idx        = r_idx;
        w_color      = r_color;
        w_valid      = r_valid;
        w_locked     = r_locked;
        w_reverse    = r_reverse;
        w_step_count = r_step_count;
        w_step       = 1'b0;
        w_seq_err    = 1'b0;
        w_tim_err    = 1'b0;
        if (r_chg) begin
            if (w_legal) begin
                w_idx   = w_new_idx;
                w_color = idx_to_code(w_new_idx);
                w_valid = 1'b1;
            end else begin
                w_valid = 1'b0;
            end
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_legal) w_state = ST_ACQUIRE;
                    else         w_seq_err = 1'b1;
                end
                ST_ACQUIRE: begin
                    if (w_is_succ) begin
                        w_state   = ST_LOCKED;
                        w_locked  = 1'b1;
                        w_reverse = 1'b0;
                    end
`ifdef COLOR_WHEEL_MONITOR_REVERSE_EN
                    else if (w_is_pred) begin
                        w_state   = ST_LOCKED;
                        w_locked  = 1'b1;
                        w_reverse = 1'b1;
                    end
`endif
                    else begin
                        w_seq_err = 1'b1;
                        if (!w_legal) w_state = ST_UNLOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_dir_ok) begin
                        if (r_dwell < DWELL_LO) begin
                            w_tim_err = 1'b1;
                        end else if (r_dwell > DWELL_HI) begin
                            w_tim_err = 1'b1;
                            w_state   = ST_ACQUIRE;
                            w_locked  = 1'b0;
                            w_reverse = 1'b0;
                        end else begin
                            w_step       = 1'b1;
                            w_step_count = r_step_count + 16'd1;
                        end
                    end else begin
                        w_seq_err = 1'b1;
                        w_locked  = 1'b0;
                        w_reverse = 1'b0;
                        w_state   = w_legal ? ST_ACQUIRE : ST_UNLOCKED;
                    end
                end
                default: w_state = ST_UNLOCKED;
            endcase
        end else if (r_state == ST_LOCKED && r_dwell >= DWELL_STALL) begin
            // Stall fires once: dropping to ACQUIRE stops further dwell checks.
            w_tim_err = 1'b1;
            w_state   = ST_ACQUIRE;
            w_locked  = 1'b0;
            w_reverse = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_UNLOCKED;
            r_idx        <= '0;
            r_color      <= '0;
            r_valid      <= 1'b0;
            r_locked     <= 1'b0;
            r_reverse    <= 1'b0;
            r_step_count <= '0;
            r_step       <= 1'b0;
            r_seq_err    <= 1'b0;
            r_tim_err    <= 1'b0;
            r_dwell      <= '0;
        end else begin
            r_state      <= w_state;
            r_idx        <= w_idx;
            r_color      <= w_color;
            r_valid      <= w_valid;
            r_locked     <= w_locked;
            r_reverse    <= w_reverse;
            r_step_count <= w_step_count;
            r_step       <= w_step;
            r_seq_err    <= w_seq_err;
            r_tim_err    <= w_tim_err;
            r_dwell      <= w_dwell;
        end
    end

    assign color        = r_color;
    assign color_valid  = r_valid;
    assign locked       = r_locked;
    assign step         = r_step;
    assign seq_error    = r_seq_err;
    assign timing_error = r_tim_err;
    assign reverse      = r_reverse;
    assign step_count   = r_step_count;

endmodule
